// File: rtl/gray_step_checker_pkg.sv
// Shared types and constants for the Gray step checker and related monitors.
package gray_step_checker_pkg;

  typedef enum logic [1:0] {
    SYNC,
    TRACK,
    FAULT
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_JUMP = 2'b01;
  localparam logic [1:0] ERR_BACK = 2'b10;
  localparam logic [1:0] ERR_OVF  = 2'b11;

  localparam int unsigned DEFAULT_WIDTH = 3;

endpackage

// File: rtl/gray_step_checker_gray2bin.sv
// Purely combinational WIDTH-bit Gray-to-binary converter.
module gray2bin #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    binary = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      binary[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_step_checker.sv
// Monitors an upstream Gray counter: checks single forward steps, pulses on
// step/wrap, counts laps and latches a sticky error with a cause code.
module gray_step_checker
  import gray_step_checker_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned LAP_WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [WIDTH-1:0]     GrayIn,
  input  logic                 OverflowIn,
  input  logic                 Clear,
  output logic [WIDTH-1:0]     Binary,
  output logic                 Step,
  output logic                 Wrap,
  output logic [LAP_WIDTH-1:0] LapCount,
  output logic                 Error,
  output logic [1:0]           ErrorCode
);

  state_t           state;
  logic [WIDTH-1:0] next;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] dec;
  logic             ovf_prev;
  logic             wrap_seen;
  logic             ovf_edge;
  logic             at_max;
  logic             step_ok;
  logic [1:0]       fault_code;

  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .gray   (GrayIn),
    .binary (next)
  );

  assign inc      = Binary + WIDTH'(1);
  assign dec      = Binary - WIDTH'(1);
  assign at_max   = (Binary == '1);
  assign ovf_edge = OverflowIn & ~ovf_prev;
  assign step_ok  = (next == inc) && (next != Binary);

  // Jump/back are exclusive with hold/step, so overflow only reaches the
  // code when the transition itself is legal, giving 01 > 10 > 11.
  always_comb begin
    fault_code = ERR_NONE;
    if (next == Binary) begin
      if (ovf_edge) fault_code = ERR_OVF;
    end else if (step_ok) begin
      if (ovf_edge && !(at_max && !wrap_seen)) fault_code = ERR_OVF;
    end else if (next == dec) begin
      fault_code = ERR_BACK;
    end else begin
      fault_code = ERR_JUMP;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= SYNC;
      Binary    <= '0;
      Step      <= 1'b0;
      Wrap      <= 1'b0;
      LapCount  <= '0;
      Error     <= 1'b0;
      ErrorCode <= ERR_NONE;
      ovf_prev  <= 1'b0;
      wrap_seen <= 1'b0;
    end else begin
      Step     <= 1'b0;
      Wrap     <= 1'b0;
      ovf_prev <= OverflowIn;
      if (Clear) begin
        state     <= SYNC;
        Binary    <= '0;
        LapCount  <= '0;
        Error     <= 1'b0;
        ErrorCode <= ERR_NONE;
        wrap_seen <= 1'b0;
      end else begin
        case (state)
          SYNC: begin
            Binary <= next;
            state  <= TRACK;
          end
          TRACK: begin
            if (fault_code != ERR_NONE) begin
              state     <= FAULT;
              Error     <= 1'b1;
              ErrorCode <= fault_code;
            end else if (step_ok) begin
              Binary <= next;
              Step   <= 1'b1;
              if (at_max) begin
                Wrap      <= 1'b1;
                wrap_seen <= 1'b1;
                if (LapCount != '1) LapCount <= LapCount + LAP_WIDTH'(1);
              end
            end
          end
          FAULT: begin
            Error <= 1'b1;
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_step_checker.sv
// Directed-vector bench for gray_step_checker with hand-computed expectations.
module tb_gray_step_checker;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [2:0] GrayIn;
  logic       OverflowIn;
  logic       Clear;

  logic [2:0] Binary, Binary2;
  logic       Step, Step2, Wrap, Wrap2, Error, Error2;
  logic [7:0] LapCount;
  logic [1:0] LapCount2;
  logic [1:0] ErrorCode, ErrorCode2;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Gray sequence for binary 0..7
  logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  always #5 Clk = ~Clk;

  gray_step_checker #(.WIDTH(3), .LAP_WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .GrayIn(GrayIn), .OverflowIn(OverflowIn), .Clear(Clear),
    .Binary(Binary), .Step(Step), .Wrap(Wrap), .LapCount(LapCount),
    .Error(Error), .ErrorCode(ErrorCode)
  );

  gray_step_checker #(.WIDTH(3), .LAP_WIDTH(2)) dut_sat (
    .Clk(Clk), .Reset(Reset), .GrayIn(GrayIn), .OverflowIn(OverflowIn), .Clear(Clear),
    .Binary(Binary2), .Step(Step2), .Wrap(Wrap2), .LapCount(LapCount2),
    .Error(Error2), .ErrorCode(ErrorCode2)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one sample; outputs are looked at 1 time unit after the edge that took it.
  task automatic apply(input logic [2:0] g, input logic o, input logic c);
    GrayIn = g; OverflowIn = o; Clear = c;
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    apply(3'b000, 1'b0, 1'b0);
    apply(3'b000, 1'b0, 1'b0);
    Reset = 1'b0;
  endtask

  // Steps 1..7 of a lap with every step checked; caller drives the wrap sample.
  task automatic lap_body(input logic o);
    for (int i = 1; i < 8; i++) begin
      apply(gseq[i], o, 1'b0);
      check("lap_step", Step, 1);
      check("lap_bin", Binary, i);
    end
  endtask

  initial begin
    Reset = 1'b1; GrayIn = '0; OverflowIn = 1'b0; Clear = 1'b0;

    // Reset state
    do_reset();
    check("rst_bin", Binary, 0);
    check("rst_step", Step, 0);
    check("rst_wrap", Wrap, 0);
    check("rst_lap", LapCount, 0);
    check("rst_err", Error, 0);
    check("rst_code", ErrorCode, 0);

    // Full lap with overflow rising on the wrap
    apply(3'b000, 1'b0, 1'b0);
    check("sync_step", Step, 0);
    check("sync_bin", Binary, 0);
    lap_body(1'b0);
    check("lap_wrap_pre", Wrap, 0);
    apply(3'b000, 1'b1, 1'b0);
    check("wrap_step", Step, 1);
    check("wrap_wrap", Wrap, 1);
    check("wrap_lap", LapCount, 1);
    check("wrap_err", Error, 0);
    check("wrap_bin", Binary, 0);

    // Hold at 011 for 10 cycles
    apply(3'b001, 1'b1, 1'b0);
    apply(3'b011, 1'b1, 1'b0);
    check("pre_hold_bin", Binary, 2);
    for (int i = 0; i < 10; i++) begin
      apply(3'b011, 1'b1, 1'b0);
      check("hold_step", Step, 0);
      check("hold_wrap", Wrap, 0);
      check("hold_bin", Binary, 2);
    end

    // Backward step 2 -> 1
    apply(3'b001, 1'b1, 1'b0);
    check("back_err", Error, 1);
    check("back_code", ErrorCode, 2);
    check("back_bin", Binary, 2);

    // Clear, then 101 becomes the baseline
    apply(3'b101, 1'b1, 1'b1);
    check("clr_err", Error, 0);
    check("clr_code", ErrorCode, 0);
    check("clr_lap", LapCount, 0);
    apply(3'b101, 1'b1, 1'b0);
    check("resync_bin", Binary, 6);
    check("resync_err", Error, 0);
    check("resync_step", Step, 0);

    // Jump 1 -> 4, then further inputs ignored
    apply(3'b001, 1'b1, 1'b1);
    apply(3'b001, 1'b1, 1'b0);
    check("jump_base", Binary, 1);
    apply(3'b110, 1'b1, 1'b0);
    check("jump_err", Error, 1);
    check("jump_code", ErrorCode, 1);
    apply(3'b111, 1'b1, 1'b0);
    apply(3'b010, 1'b1, 1'b0);
    check("fault_code", ErrorCode, 1);
    check("fault_bin", Binary, 1);
    check("fault_step", Step, 0);
    check("fault_err", Error, 1);

    // Overflow rising on a plain step (gray 010, bin 3)
    do_reset();
    apply(3'b000, 1'b0, 1'b0);
    apply(3'b001, 1'b0, 1'b0);
    apply(3'b011, 1'b0, 1'b0);
    apply(3'b010, 1'b1, 1'b0);
    check("ovf_err", Error, 1);
    check("ovf_code", ErrorCode, 3);
    check("ovf_step", Step, 0);

    // Jump beats overflow edge in the same cycle
    do_reset();
    apply(3'b000, 1'b0, 1'b0);
    apply(3'b101, 1'b1, 1'b0);
    check("prio_jump", ErrorCode, 1);

    // Backward beats overflow edge in the same cycle
    do_reset();
    apply(3'b000, 1'b0, 1'b0);
    apply(3'b100, 1'b1, 1'b0);
    check("prio_back", ErrorCode, 2);

    // Overflow edge on the second wrap is illegal
    do_reset();
    apply(3'b000, 1'b0, 1'b0);
    lap_body(1'b0);
    apply(3'b000, 1'b0, 1'b0);
    check("w1_wrap", Wrap, 1);
    check("w1_err", Error, 0);
    lap_body(1'b0);
    apply(3'b000, 1'b1, 1'b0);
    check("w2_wrap", Wrap, 0);
    check("w2_code", ErrorCode, 3);

    // Five laps: 2-bit lap counter saturates, Wrap still pulses
    do_reset();
    apply(3'b000, 1'b0, 1'b0);
    for (int n = 1; n <= 5; n++) begin
      lap_body(n > 1);
      apply(3'b000, 1'b1, 1'b0);
      check("sat_wrap", Wrap2, 1);
      check("sat_lap2", LapCount2, (n > 3) ? 3 : n);
      check("sat_lap8", LapCount, n);
      check("sat_err", Error2, 0);
    end

    // Clear on the same cycle as an illegal jump
    do_reset();
    apply(3'b000, 1'b0, 1'b0);
    apply(3'b001, 1'b0, 1'b0);
    apply(3'b111, 1'b0, 1'b1);
    check("clrj_err", Error, 0);
    check("clrj_code", ErrorCode, 0);
    check("clrj_step", Step, 0);
    check("clrj_lap", LapCount, 0);
    check("clrj_bin", Binary, 0);
    apply(3'b111, 1'b0, 1'b0);
    check("clrj_base", Binary, 5);
    check("clrj_err2", Error, 0);
    apply(3'b101, 1'b0, 1'b0);
    check("clrj_step2", Step, 1);
    check("clrj_bin2", Binary, 6);

    // Reset mid-sequence
    apply(3'b100, 1'b0, 1'b0);
    apply(3'b000, 1'b1, 1'b0);
    check("mid_lap", LapCount, 1);
    Reset = 1'b1;
    apply(3'b011, 1'b1, 1'b0);
    check("mrst_bin", Binary, 0);
    check("mrst_lap", LapCount, 0);
    check("mrst_step", Step, 0);
    check("mrst_wrap", Wrap, 0);
    check("mrst_err", Error, 0);
    Reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gray_step_checker.md
# gray_step_checker

Monitor stage placed directly downstream of the 3-bit Gray counter. Samples the counter's Gray output and overflow flag every cycle and converts Gray to binary. Checks that every change is a legal single forward step, pulses on each step and on each wrap, and counts completed laps. Latches a sticky error with a cause code on any illegal transition, until cleared.

## Interface
- WIDTH, 3, Gray/binary code width; must match the upstream counter.
- LAP_WIDTH, 8, width of the lap counter.
- Clk  in  1  clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- GrayIn  in  WIDTH  Gray code from the upstream counter; same clock domain, no synchronizer.
- OverflowIn  in  1  sticky overflow flag from the upstream counter.
- Clear  in  1  synchronous clear of error, laps and baseline; one-cycle pulse or level.
- Binary  out  WIDTH  registered binary value of the last accepted sample.
- Step  out  1  one-cycle pulse: sample advanced by exactly +1 (including the wrap).
- Wrap  out  1  one-cycle pulse: sample went from 2^WIDTH-1 to 0.
- LapCount  out  LAP_WIDTH  number of wraps; saturates at all-ones.
- Error  out  1  sticky fault flag.
- ErrorCode  out  2  00 none, 01 jump, 10 backward step, 11 overflow mismatch.

## Operation
- Conversion: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i]. prev = stored binary; next = conversion of GrayIn.
- FSM states:
  - SYNC: the first sample after Reset or Clear is accepted as the baseline with no check. Binary is loaded and the prior OverflowIn is recorded. Go to TRACK.
  - TRACK: classify each sample, in this order:
    - next==prev: hold; no pulses.
    - next==(prev+1) mod 2^WIDTH: Binary<=next and Step=1.
      - If prev==2^WIDTH-1, also Wrap=1 and LapCount+1 (saturating).
    - next==(prev-1) mod 2^WIDTH: ErrorCode=10, go to FAULT.
    - Any other value: ErrorCode=01, go to FAULT.
  - FAULT: Error=1. Binary, LapCount and ErrorCode are frozen, no pulses. Leave only via Clear or Reset, to SYNC.
- Overflow check, applied in TRACK only:
  - A 0->1 edge of OverflowIn must coincide with the first Wrap detected since Reset or Clear.
  - An edge in any other cycle gives ErrorCode=11, FAULT.
  - A Wrap while OverflowIn is already 1 is legal.
- If several faults are detected in one cycle, the priority is 01 > 10 > 11.
- Priority: Reset > Clear > FSM activity. A Clear in the same cycle as a fault wins: no error is latched.

## Timing
- Reset values: Binary=0, Step=0, Wrap=0, LapCount=0, Error=0, ErrorCode=00, state SYNC.
- All outputs are registered.
  - Step, Wrap, Error and Binary appear one cycle after the GrayIn sample that caused them.
- Upstream wrap cycle: the counter shows 000 and Overflow=1 on the same edge. The checker pulses Wrap and Step on the following edge.
- Clear: on the next edge Error=0, ErrorCode=00, LapCount=0, state SYNC. The baseline is taken from the sample in the cycle after Clear.
- LapCount at all-ones stays all-ones; Wrap still pulses.

## Structure
- Shared package holds:
  - the state enum {SYNC, TRACK, FAULT};
  - the ErrorCode constants ERR_NONE, ERR_JUMP, ERR_BACK, ERR_OVF;
  - the default WIDTH.
- One sub-module, gray2bin: parameterized, purely combinational WIDTH-bit Gray-to-binary converter, also reusable by other monitors.
- The top level holds the FSM, the prev register, the OverflowIn edge register and the lap counter.

## Test plan
- Reset, then drive 000,001,011,010,110,111,101,100,000 with OverflowIn rising on the final 000:
  - Step pulses 8 times; Wrap pulses once; LapCount=1; Error=0; Binary ends at 0.
- GrayIn held at 011 for 10 cycles: no pulses; Binary stays 2.
- From 001 (bin 1), drive 110 (bin 4): Error=1 and ErrorCode=01 one cycle later. Further inputs are ignored; Binary stays 1.
- From 011 (bin 2), drive 001 (bin 1): ErrorCode=10.
  - Then Clear and drive 101: SYNC accepts the baseline, Binary=6, no Error.
- Raise OverflowIn at 010 with no wrap: ErrorCode=11.
  - Separately, with LAP_WIDTH=2 run 5 laps: LapCount saturates at 3 while Wrap still pulses.
- Assert Reset and Clear mid-sequence, including Clear on the same cycle as an illegal jump: all outputs return to reset values and Error stays 0.
